// File: rtl/picorv32_mem_req_ctrl_pkg.sv
// Shared types and widths for the PicoRV32 memory request controller slice.
package picorv32_mem_pkg;

    localparam int WORD_W = 32;
    localparam int STRB_W = 4;
    localparam int TAG_W  = WORD_W - 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        HIT  = 2'd2
    } mem_ctrl_state_t;

endpackage

// File: rtl/picorv32_mem_req_ctrl_if.sv
// Native PicoRV32 memory bus: request from the controller, response from memory.
interface picorv32_mem_req_ctrl_if;
    import picorv32_mem_pkg::*;

    logic              mem_valid;
    logic              mem_instr;
    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic              mem_ready;
    logic [WORD_W-1:0] mem_rdata;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/picorv32_mem_req_ctrl_prefetch_buf.sv
// One-word instruction buffer: tag, data and valid bit with a combinational hit.
module picorv32_prefetch_buf
    import picorv32_mem_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic [TAG_W-1:0]  lookup_tag,
    output logic              hit,
    output logic [WORD_W-1:0] data,
    input  logic              fill,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic [WORD_W-1:0] fill_data,
    input  logic              invalidate,
    input  logic              flush
);

    logic             valid;
    logic [TAG_W-1:0] tag;

    // Invalidate and flush take priority over a fill in the same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else begin
            if (fill) begin
                tag  <= fill_tag;
                data <= fill_data;
            end
            if (invalidate || flush)
                valid <= 1'b0;
            else if (fill)
                valid <= 1'b1;
        end
    end

    assign hit = valid && (tag == lookup_tag);

endmodule

// File: rtl/picorv32_mem_req_ctrl.sv
// PicoRV32 memory request controller; PICORV32_MEM_TIMEOUT_EN enables the bus abort timer.
module picorv32_mem_req_ctrl
    import picorv32_mem_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [WORD_W-1:0]             req_addr,
    input  logic [WORD_W-1:0]             req_wdata,
    input  logic [STRB_W-1:0]             req_wstrb,
    input  logic                          req_instr,
    input  logic                          buf_flush,
    picorv32_mem_req_ctrl_if.master       mem_bus,
    output logic                          mem_do_rinst,
    output logic                          mem_la_use_prefetched_high_word,
    output logic                          mem_xfer,
    output logic [WORD_W-1:0]             rsp_rdata,
    output logic                          mem_timeout
);

    mem_ctrl_state_t   state, state_nxt;
    logic [TAG_W-1:0]  lat_tag;
    logic [WORD_W-1:0] lat_wdata;
    logic [STRB_W-1:0] lat_wstrb;
    logic              lat_instr;
    logic              in_bus, in_hit, accept, take_hit, bus_done, timeout_fire;
    logic              buf_hit, buf_fill, buf_inval;
    logic [WORD_W-1:0] buf_data;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^req_addr[1:0];

    assign in_bus    = (state == BUS);
    assign in_hit    = (state == HIT);
    // Held low during reset so the core never sees an acceptance while resetn is low.
    assign req_ready = resetn && (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign take_hit  = req_instr && (req_wstrb == '0) && buf_hit;
    assign bus_done  = in_bus && mem_bus.mem_ready;
    assign buf_fill  = bus_done && lat_instr && (lat_wstrb == '0);
    assign buf_inval = (bus_done && (lat_wstrb != '0)) || timeout_fire;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = take_hit ? HIT : BUS;
            BUS:     if (bus_done || timeout_fire) state_nxt = IDLE;
            HIT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            lat_tag   <= '0;
            lat_wdata <= '0;
            lat_wstrb <= '0;
            lat_instr <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                lat_tag   <= req_addr[WORD_W-1:2];
                lat_wdata <= req_wdata;
                lat_wstrb <= req_wstrb;
                lat_instr <= req_instr;
            end
        end
    end

`ifdef PICORV32_MEM_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_q;

    // Count only BUS cycles that end without mem_ready; cleared whenever not on the bus.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_fire;
            if (!in_bus)
                wait_cnt <= '0;
            else if (!mem_bus.mem_ready)
                wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign timeout_fire = in_bus && !mem_bus.mem_ready && (wait_cnt == CNT_LAST);
    assign mem_timeout  = timeout_q;
`else
    localparam int unused_timeout = TIMEOUT;
    assign timeout_fire = 1'b0;
    assign mem_timeout  = 1'b0;
`endif

    picorv32_prefetch_buf u_prefetch_buf (
        .clk        (clk),
        .resetn     (resetn),
        .lookup_tag (req_addr[WORD_W-1:2]),
        .hit        (buf_hit),
        .data       (buf_data),
        .fill       (buf_fill),
        .fill_tag   (lat_tag),
        .fill_data  (mem_bus.mem_rdata),
        .invalidate (buf_inval),
        .flush      (buf_flush)
    );

    assign mem_bus.mem_valid = in_bus;
    assign mem_bus.mem_instr = in_bus && lat_instr;
    assign mem_bus.mem_addr  = in_bus ? {lat_tag, 2'b00} : '0;
    assign mem_bus.mem_wdata = in_bus ? lat_wdata : '0;
    assign mem_bus.mem_wstrb = in_bus ? lat_wstrb : '0;

    assign mem_do_rinst                    = in_hit || (in_bus && lat_instr);
    assign mem_la_use_prefetched_high_word = in_hit;
    assign mem_xfer  = (mem_bus.mem_valid && mem_bus.mem_ready) ||
                       (mem_la_use_prefetched_high_word && mem_do_rinst);
    assign rsp_rdata = in_hit ? buf_data : (in_bus ? mem_bus.mem_rdata : '0);

endmodule

// File: doc/picorv32_mem_req_ctrl.md
# picorv32_mem_req_ctrl

Memory request controller between the PicoRV32 core's load/store/fetch logic and the native memory bus. Latches one core request, drives the `mem_valid`/`mem_ready` handshake with stable address/data, and keeps a one-word instruction buffer so a second fetch from the same word completes without a bus transaction. It also generates the `mem_do_rinst` and `mem_la_use_prefetched_high_word` signals consumed by the transfer-detect logic, plus a correctly gated `mem_xfer`.

## Interface
- `TIMEOUT`, default 256: bus cycles allowed before abort (used only with the timeout feature; must be ≥2).
- `clk` in 1: clock, all state on rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: core request pending.
- `req_ready` out 1: request accepted this cycle if `req_valid`.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: write data.
- `req_wstrb` in 4: byte enables; 0 means read.
- `req_instr` in 1: request is an instruction fetch.
- `buf_flush` in 1: invalidate the instruction buffer.
- `mem_valid` out 1, `mem_instr` out 1, `mem_addr` out 32, `mem_wdata` out 32, `mem_wstrb` out 4: native bus request.
- `mem_ready` in 1, `mem_rdata` in 32: native bus response.
- `mem_do_rinst` out 1: the current operation is an instruction fetch.
- `mem_la_use_prefetched_high_word` out 1: the current fetch is served from the buffer.
- `mem_xfer` out 1: transfer completes this cycle.
- `rsp_rdata` out 32: read data, valid when `mem_xfer`.
- `mem_timeout` out 1: one-cycle abort pulse.

## Operation
- FSM states IDLE, BUS, HIT. Reset state is IDLE. All outputs reset to 0, buffer invalid, counter 0.
- `req_ready` = (state==IDLE). On acceptance, latch addr/wdata/wstrb/instr.
  - Go to HIT if `req_instr`, `req_wstrb==0`, buffer valid, and `req_addr[31:2]==buf_addr`.
  - Otherwise go to BUS.
- BUS: `mem_valid`=1. `mem_addr` = {latched addr[31:2],2'b00}. Bus outputs are held constant until completion. `mem_do_rinst`=latched instr.
- HIT: `mem_valid`=0, `mem_do_rinst`=1, `mem_la_use_prefetched_high_word`=1, `rsp_rdata`=buffer data.
- `mem_xfer` = (`mem_valid` && `mem_ready`) || (`mem_la_use_prefetched_high_word` && `mem_do_rinst`). It must be an AND of valid and ready; `mem_ready` while `mem_valid`=0 is ignored.
- Completion in BUS: `rsp_rdata`=`mem_rdata`, return to IDLE.
  - Instruction read: buffer ← (addr[31:2], `mem_rdata`), valid.
  - Any write (wstrb≠0): invalidate buffer.
- HIT always returns to IDLE after one cycle.
- `buf_flush` invalidates the buffer. A flush in the same cycle as a buffer fill wins (buffer ends invalid).

## Timing
- Accept in cycle N → `mem_valid` rises in N+1.
- `mem_ready` in cycle M≥N+1 → `mem_xfer`=1 in cycle M (combinational). `mem_valid`=0 and `req_ready`=1 in M+1.
- Buffer hit: accept in N → HIT with `mem_xfer`=1 in N+1 → IDLE in N+2.
- Minimum spacing between accepts is 2 cycles.
- A `resetn` assertion mid-transaction drops `mem_valid` asynchronously. No response is produced.

## Configuration
- `PICORV32_MEM_TIMEOUT_EN` defined:
  - Counter (width $clog2(TIMEOUT)+1) clears on entering BUS and increments each BUS cycle without `mem_ready`.
  - On the BUS cycle where the count equals TIMEOUT-1 and `mem_ready`=0, the next cycle goes to IDLE with `mem_valid`=0, `mem_timeout`=1 for one cycle, `mem_xfer`=0, and the buffer invalidated.
  - `mem_ready` in that final cycle still completes normally.
- Undefined: no counter; `mem_timeout` is tied to 0; BUS waits indefinitely.

## Structure
- Package `picorv32_mem_pkg`: state enum `mem_ctrl_state_t` (IDLE/BUS/HIT), `WORD_W`=32, `STRB_W`=4.
- Sub-module `picorv32_prefetch_buf`: holds tag, data, and valid bit, with fill/invalidate/flush inputs and a combinational hit output.

## Test plan
- Read at 0x100: accept; `mem_ready` held low 3 cycles, then high → `mem_xfer` exactly once; `rsp_rdata`=`mem_rdata`; `mem_addr`=0x100 stable throughout.
- Fetch 0x200 (rdata 0xDEADBEEF), then fetch 0x202 → second fetch has no `mem_valid`; HIT cycle has `mem_la_use_prefetched_high_word`=1, `mem_xfer`=1, `rsp_rdata`=0xDEADBEEF.
- Fetch 0x200, write 0x300, fetch 0x202 → third request goes to the bus (buffer invalidated).
- `mem_ready` pulsed while IDLE → `mem_xfer` stays 0.
- Fetch fill coinciding with `buf_flush` → next fetch to the same word uses the bus.
- With `PICORV32_MEM_TIMEOUT_EN`, TIMEOUT=4, `mem_ready` never asserted → `mem_valid` high 4 cycles, then `mem_timeout` pulses, FSM in IDLE, `mem_xfer` never 1. Reset asserted mid-BUS → all outputs 0 immediately.
